sparc_control_fsm: RTL and testbench

Multicycle microsequencer. Replaces the purely combinational decoder with a registered FSM that fetches, decodes and executes SPARC V8 format 1/2/3 instructions, and handshakes with RAM through MFC. It drives every datapath enable and mux select, evaluates all 16 Bicc conditions from icc, and controls nPC/PC sequencing. Sits between IR/PSR and the datapath (PC, nPC, MAR, MDR, register file, ALU, RAM).

---
 rtl/sparc_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sparc_control_fsm.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_control_fsm.sv
// ============================================================================
// Module   : sparc_control_fsm
// Brief    : Multicycle SPARC V8 microsequencer (fetch / decode / execute, MFC
//            handshake). Optional MFC wait timeout: define CU_MFC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparc_control_fsm #(
    parameter int ALU_OP_W    = 6,
    parameter int REG_W       = 5,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ir_out,
    input  logic                mfc,
    input  logic [3:0]          icc,
    output logic                ir_enable,
    output logic                mar_enable,
    output logic                mdr_enable,
    output logic                mdr_mux_select,
    output logic                ram_enable,
    output logic [5:0]          ram_opcode,
    output logic                pc_enable,
    output logic                npc_enable,
    output logic [1:0]          pc_mux_select,
    output logic                register_file,
    output logic                psr_enable,
    output logic [REG_W-1:0]    in_pc,
    output logic [REG_W-1:0]    in_pa,
    output logic [REG_W-1:0]    in_pb,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alub_mux_select,
    output logic [1:0]          extender_select,
    output logic                branch_taken,
    output logic                mem_error,
    output logic [3:0]          state
);

    localparam logic [3:0] c_ST_RESET      = 4'd0;
    localparam logic [3:0] c_ST_FETCH_ADDR = 4'd1;
    localparam logic [3:0] c_ST_FETCH_WAIT = 4'd2;
    localparam logic [3:0] c_ST_FETCH_LOAD = 4'd3;
    localparam logic [3:0] c_ST_DECODE     = 4'd4;
    localparam logic [3:0] c_ST_ALU        = 4'd5;
    localparam logic [3:0] c_ST_BRANCH     = 4'd6;
    localparam logic [3:0] c_ST_CALL       = 4'd7;
    localparam logic [3:0] c_ST_MEM_ADDR   = 4'd8;
    localparam logic [3:0] c_ST_UPDATE_PC  = 4'd9;
    localparam logic [3:0] c_ST_MEM_WAIT   = 4'd10;
    localparam logic [3:0] c_ST_MEM_WB     = 4'd11;
    localparam logic [3:0] c_ST_ERROR      = 4'd12;

    logic [3:0] r_state;
    logic       r_branch_taken;
    logic       r_mem_error;

    logic [1:0] w_op;
    logic [2:0] w_op2;
    logic [3:0] w_cond;
    logic [5:0] w_op3;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_imm;
    logic       w_store;
    logic       w_n, w_z, w_v, w_c;
    logic       w_cond_true;
    logic       w_timeout;
    logic       w_unused_ok;

    assign w_op    = ir_out[31:30];
    assign w_op2   = ir_out[24:22];
    assign w_cond  = ir_out[28:25];
    assign w_op3   = ir_out[24:19];
    assign w_rd    = ir_out[29:25];
    assign w_rs1   = ir_out[18:14];
    assign w_rs2   = ir_out[4:0];
    assign w_imm   = ir_out[13];
    assign w_store = ir_out[21];
    assign {w_n, w_z, w_v, w_c} = icc;

    // Immediate bits reach the datapath extender directly, not through here.
    assign w_unused_ok = ^{ir_out[12:5], MFC_TIMEOUT[0]};

    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            4'b1000: w_cond_true = 1'b1;
            4'b0000: w_cond_true = 1'b0;
            4'b1001: w_cond_true = ~w_z;
            4'b0001: w_cond_true = w_z;
            4'b1010: w_cond_true = ~(w_z | (w_n ^ w_v));
            4'b0010: w_cond_true = w_z | (w_n ^ w_v);
            4'b1011: w_cond_true = ~(w_n ^ w_v);
            4'b0011: w_cond_true = w_n ^ w_v;
            4'b1100: w_cond_true = ~(w_c | w_z);
            4'b0100: w_cond_true = w_c | w_z;
            4'b1101: w_cond_true = ~w_c;
            4'b0101: w_cond_true = w_c;
            4'b1110: w_cond_true = ~w_n;
            4'b0110: w_cond_true = w_n;
            4'b1111: w_cond_true = ~w_v;
            4'b0111: w_cond_true = w_v;
            default: w_cond_true = 1'b0;
        endcase
    end

`ifdef CU_MFC_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(MFC_TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_wait_cnt;

    // Error is taken on the edge that would complete the MFC_TIMEOUT-th idle wait cycle.
    assign w_timeout = ~mfc && (r_wait_cnt == c_CNT_W'(MFC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_FETCH_ADDR || r_state == c_ST_MEM_ADDR) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_ST_FETCH_WAIT || r_state == c_ST_MEM_WAIT) && !mfc) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= c_ST_RESET;
            r_branch_taken <= 1'b0;
            r_mem_error    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RESET:      r_state <= c_ST_FETCH_ADDR;
                c_ST_FETCH_ADDR: r_state <= c_ST_FETCH_WAIT;
                c_ST_FETCH_WAIT: begin
                    if (mfc) begin
                        r_state <= c_ST_FETCH_LOAD;
                    end else if (w_timeout) begin
                        r_state     <= c_ST_ERROR;
                        r_mem_error <= 1'b1;
                    end
                end
                c_ST_FETCH_LOAD: r_state <= c_ST_DECODE;
                c_ST_DECODE: begin
                    r_branch_taken <= w_cond_true;
                    case (w_op)
                        2'b00:   r_state <= (w_op2 == 3'b010) ? c_ST_BRANCH : c_ST_UPDATE_PC;
                        2'b01:   r_state <= c_ST_CALL;
                        2'b10:   r_state <= c_ST_ALU;
                        default: r_state <= c_ST_MEM_ADDR;
                    endcase
                end
                c_ST_ALU:        r_state <= c_ST_UPDATE_PC;
                c_ST_BRANCH:     r_state <= c_ST_FETCH_ADDR;
                c_ST_CALL:       r_state <= c_ST_FETCH_ADDR;
                c_ST_MEM_ADDR:   r_state <= c_ST_MEM_WAIT;
                c_ST_MEM_WAIT: begin
                    if (mfc) begin
                        r_state <= w_store ? c_ST_UPDATE_PC : c_ST_MEM_WB;
                    end else if (w_timeout) begin
                        r_state     <= c_ST_ERROR;
                        r_mem_error <= 1'b1;
                    end
                end
                c_ST_MEM_WB:     r_state <= c_ST_UPDATE_PC;
                c_ST_UPDATE_PC:  r_state <= c_ST_FETCH_ADDR;
                c_ST_ERROR:      r_state <= c_ST_ERROR;
                default:         r_state <= c_ST_RESET;
            endcase
        end
    end

    always_comb begin
        ir_enable       = 1'b0;
        mar_enable      = 1'b0;
        mdr_enable      = 1'b0;
        mdr_mux_select  = 1'b0;
        ram_enable      = 1'b0;
        ram_opcode      = 6'b000000;
        pc_enable       = 1'b0;
        npc_enable      = 1'b0;
        pc_mux_select   = 2'b00;
        register_file   = 1'b0;
        psr_enable      = 1'b0;
        in_pc           = '0;
        in_pa           = '0;
        in_pb           = '0;
        alu_op          = '0;
        alub_mux_select = 2'b00;
        extender_select = 2'b00;
        case (r_state)
            c_ST_FETCH_ADDR: mar_enable = 1'b1;
            c_ST_FETCH_WAIT: begin
                ram_enable = 1'b1;
                mdr_enable = mfc;
            end
            c_ST_FETCH_LOAD: ir_enable = 1'b1;
            c_ST_ALU: begin
                in_pc         = REG_W'(w_rd);
                in_pa         = REG_W'(w_rs1);
                alu_op        = ALU_OP_W'(w_op3);
                register_file = 1'b1;
                psr_enable    = ir_out[23];
                if (w_imm) alub_mux_select = 2'b01;
                else       in_pb = REG_W'(w_rs2);
            end
            c_ST_BRANCH: begin
                extender_select = 2'b01;
                pc_enable       = 1'b1;
                npc_enable      = 1'b1;
                pc_mux_select   = r_branch_taken ? 2'b01 : 2'b00;
            end
            c_ST_CALL: begin
                register_file   = 1'b1;
                in_pc           = REG_W'(15);
                extender_select = 2'b10;
                pc_mux_select   = 2'b10;
                pc_enable       = 1'b1;
                npc_enable      = 1'b1;
            end
            c_ST_MEM_ADDR: begin
                in_pa      = REG_W'(w_rs1);
                mar_enable = 1'b1;
                if (w_imm) alub_mux_select = 2'b01;
                else       in_pb = REG_W'(w_rs2);
                // Store data goes out through the B port into MDR alongside the address.
                if (w_store) begin
                    mdr_mux_select = 1'b1;
                    mdr_enable     = 1'b1;
                    in_pb          = REG_W'(w_rd);
                end
            end
            c_ST_MEM_WAIT: begin
                ram_enable = 1'b1;
                ram_opcode = w_op3;
                mdr_enable = mfc & ~w_store;
            end
            c_ST_MEM_WB: begin
                register_file = 1'b1;
                in_pc         = REG_W'(w_rd);
            end
            c_ST_UPDATE_PC: begin
                pc_enable  = 1'b1;
                npc_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign branch_taken = r_branch_taken;
    assign mem_error    = r_mem_error;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sparc_control_fsm.sv
// ============================================================================
// Module   : tb_sparc_control_fsm
// Brief    : Directed bench with a behavioural sequencer model for
//            sparc_control_fsm (timeout expectations follow CU_MFC_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparc_control_fsm;

    localparam int MFC_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir_out = 32'h0;
    logic        mfc = 1'b0;
    logic [3:0]  icc = 4'h0;

    logic       ir_enable, mar_enable, mdr_enable, mdr_mux_select, ram_enable;
    logic [5:0] ram_opcode;
    logic       pc_enable, npc_enable;
    logic [1:0] pc_mux_select;
    logic       register_file, psr_enable;
    logic [4:0] in_pc, in_pa, in_pb;
    logic [5:0] alu_op;
    logic [1:0] alub_mux_select, extender_select;
    logic       branch_taken, mem_error;
    logic [3:0] state;

    sparc_control_fsm #(.ALU_OP_W(6), .REG_W(5), .MFC_TIMEOUT(MFC_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .ir_out(ir_out), .mfc(mfc), .icc(icc),
        .ir_enable(ir_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
        .mdr_mux_select(mdr_mux_select), .ram_enable(ram_enable), .ram_opcode(ram_opcode),
        .pc_enable(pc_enable), .npc_enable(npc_enable), .pc_mux_select(pc_mux_select),
        .register_file(register_file), .psr_enable(psr_enable),
        .in_pc(in_pc), .in_pa(in_pa), .in_pb(in_pb), .alu_op(alu_op),
        .alub_mux_select(alub_mux_select), .extender_select(extender_select),
        .branch_taken(branch_taken), .mem_error(mem_error), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_mux;
        logic       ram_en;
        logic [5:0] ram_op;
        logic       pc_en;
        logic       npc_en;
        logic [1:0] pc_mux;
        logic       rf;
        logic       psr;
        logic [4:0] in_pc;
        logic [4:0] in_pa;
        logic [4:0] in_pb;
        logic [5:0] alu_op;
        logic [1:0] alub;
        logic [1:0] ext;
    } outs_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.ir_en = ir_enable;   o.mar_en = mar_enable; o.mdr_en = mdr_enable;
        o.mdr_mux = mdr_mux_select; o.ram_en = ram_enable; o.ram_op = ram_opcode;
        o.pc_en = pc_enable;   o.npc_en = npc_enable; o.pc_mux = pc_mux_select;
        o.rf = register_file;  o.psr = psr_enable;
        o.in_pc = in_pc; o.in_pa = in_pa; o.in_pb = in_pb; o.alu_op = alu_op;
        o.alub = alub_mux_select; o.ext = extender_select;
        return o;
    endfunction

    // Bicc: the low three cond bits choose a base test, cond[3] negates it.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, b;
        {n, z, v, cy} = f;
        case (c[2:0])
            3'd0: b = 1'b0;
            3'd1: b = z;
            3'd2: b = z | (n ^ v);
            3'd3: b = n ^ v;
            3'd4: b = cy | z;
            3'd5: b = cy;
            3'd6: b = n;
            default: b = v;
        endcase
        return b ^ c[3];
    endfunction

    function automatic outs_t exp_outs(input int st, input logic [31:0] ir, input logic m, input logic tk);
        outs_t o;
        o = '0;
        case (st)
            1: o.mar_en = 1'b1;
            2: begin o.ram_en = 1'b1; o.mdr_en = m; end
            3: o.ir_en = 1'b1;
            5: begin
                o.in_pc = ir[29:25]; o.in_pa = ir[18:14]; o.alu_op = ir[24:19];
                o.rf = 1'b1; o.psr = ir[23];
                if (ir[13]) o.alub = 2'b01; else o.in_pb = ir[4:0];
            end
            6: begin o.ext = 2'b01; o.pc_en = 1'b1; o.npc_en = 1'b1; o.pc_mux = tk ? 2'b01 : 2'b00; end
            7: begin o.rf = 1'b1; o.in_pc = 5'd15; o.ext = 2'b10; o.pc_mux = 2'b10; o.pc_en = 1'b1; o.npc_en = 1'b1; end
            8: begin
                o.in_pa = ir[18:14]; o.mar_en = 1'b1;
                if (ir[13]) o.alub = 2'b01; else o.in_pb = ir[4:0];
                if (ir[21]) begin o.mdr_mux = 1'b1; o.mdr_en = 1'b1; o.in_pb = ir[29:25]; end
            end
            9:  begin o.pc_en = 1'b1; o.npc_en = 1'b1; end
            10: begin o.ram_en = 1'b1; o.ram_op = ir[24:19]; o.mdr_en = m & ~ir[21]; end
            11: begin o.rf = 1'b1; o.in_pc = ir[29:25]; end
            default: ;
        endcase
        return o;
    endfunction

    int   m_state = 0;
    logic m_taken = 1'b0;
    logic m_err = 1'b0;
    int   m_waits = 0;
    int   mfc_delay = 0;
    bit   hold_low = 1'b0;
    int   wc = 0;
    bit   in_wait = 1'b0;

    // Model step on the edge, then the RAM responder drives mfc 1 time unit later.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_state = 0; m_taken = 1'b0; m_err = 1'b0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin m_state = 2; m_waits = 0; end
                2, 10: begin
                    if (mfc) begin
                        if (m_state == 2) m_state = 3;
                        else              m_state = ir_out[21] ? 9 : 11;
                    end else begin
                        m_waits++;
`ifdef CU_MFC_TIMEOUT_EN
                        if (m_waits == MFC_TIMEOUT) begin m_state = 12; m_err = 1'b1; end
`endif
                    end
                end
                3: m_state = 4;
                4: begin
                    m_taken = model_cond(ir_out[28:25], icc);
                    case (ir_out[31:30])
                        2'b00: m_state = (ir_out[24:22] == 3'b010) ? 6 : 9;
                        2'b01: m_state = 7;
                        2'b10: m_state = 5;
                        default: m_state = 8;
                    endcase
                end
                5, 11: m_state = 9;
                6, 7, 9: m_state = 1;
                8: begin m_state = 10; m_waits = 0; end
                12: m_state = 12;
                default: m_state = 0;
            endcase
        end
        #1;
        if (m_state == 2 || m_state == 10) begin
            if (!in_wait) wc = 0; else wc++;
            in_wait = 1'b1;
            mfc = !hold_low && (wc >= mfc_delay);
        end else begin
            in_wait = 1'b0;
            mfc = 1'b0;
        end
    end

    always @(negedge clk) begin
        outs_t e;
        e = exp_outs(m_state, ir_out, mfc, m_taken);
        check("state", 64'(state), 64'(m_state[3:0]));
        check("outputs", 64'(dut_outs()), 64'(e));
        check("branch_taken", 64'(branch_taken), 64'(m_taken));
        check("mem_error", 64'(mem_error), 64'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int target, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (m_state != target && n < budget);
        check("reach_state", 64'(state), 64'(target));
    endtask

    task automatic instr(input logic [31:0] ir, input int dly);
        int n;
        ir_out = ir;
        mfc_delay = dly;
        run_until(1, 100, n);
    endtask

    initial begin
        int n;
        ir_out = 32'h86006005;
        tick(); tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_outs", 64'(dut_outs()), 64'd0);
        check("rst_flags", 64'({branch_taken, mem_error}), 64'd0);
        reset_n = 1'b1;
        tick(); check("seq_1", 64'(state), 64'd1);
        tick(); check("seq_2", 64'(state), 64'd2);
        tick(); check("seq_3", 64'(state), 64'd3);
        tick(); check("seq_4", 64'(state), 64'd4);
        tick(); check("seq_alu", 64'(state), 64'd5);
        check("alu_fields", 64'({in_pc, in_pa, alub_mux_select, register_file, psr_enable}),
              64'({5'd3, 5'd1, 2'b01, 1'b1, 1'b0}));
        tick(); check("seq_upd", 64'(state), 64'd9);
        tick();

        // add %g1,5,%g3 with three idle wait cycles: 9 edges back to FETCH_ADDR
        ir_out = 32'h86006005; mfc_delay = 3;
        run_until(1, 50, n);
        check("alu_latency", 64'(n), 64'd9);

        ir_out = 32'h86804002; mfc_delay = 0;  // addcc %g1,%g2,%g3
        run_until(5, 20, n);
        check("addcc_fields", 64'({psr_enable, in_pb, alub_mux_select}), 64'({1'b1, 5'd2, 2'b00}));
        run_until(1, 20, n);

        icc = 4'b0000; ir_out = 32'h12800008;  // bne, Z=0
        run_until(6, 20, n);
        check("bne_taken", 64'({branch_taken, pc_mux_select}), 64'({1'b1, 2'b01}));
        run_until(1, 20, n);
        icc = 4'b0100;                          // bne, Z=1
        run_until(6, 20, n);
        check("bne_not_taken", 64'({branch_taken, pc_mux_select}), 64'({1'b0, 2'b00}));
        run_until(1, 20, n);

        ir_out = 32'h40000010;                  // call
        run_until(7, 20, n);
        check("call_fields", 64'({in_pc, pc_mux_select, extender_select}), 64'({5'd15, 2'b10, 2'b10}));
        run_until(1, 20, n);

        instr(32'h01000000, 1);                 // sethi-format, treated as nop

        ir_out = 32'hC4006004; mfc_delay = 2;   // ld [%g1+4],%g2
        run_until(8, 20, n);
        tick(); check("ld_wait", 64'({state, ram_opcode}), 64'({4'd10, 6'd0}));
        run_until(11, 20, n);
        check("ld_wb", 64'({register_file, in_pc}), 64'({1'b1, 5'd2}));
        tick(); check("ld_upd", 64'(state), 64'd9);
        run_until(1, 20, n);

        ir_out = 32'hC4206004; mfc_delay = 1;   // st %g2,[%g1+4]
        run_until(8, 20, n);
        check("st_addr", 64'({mdr_mux_select, mdr_enable, in_pb}), 64'({1'b1, 1'b1, 5'd2}));
        run_until(1, 20, n);

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                icc = f[3:0];
                instr({2'b00, 1'b0, c[3:0], 3'b010, 22'd4}, 0);
            end
        end

        hold_low = 1'b1;
        ir_out = 32'h86006005;
`ifdef CU_MFC_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        check("timeout_err", 64'({state, mem_error}), 64'({4'd12, 1'b1}));
        for (int i = 0; i < 5; i++) tick();
        check("err_sticky", 64'({state, mem_error, ram_enable}), 64'({4'd12, 1'b1, 1'b0}));
`else
        for (int i = 0; i < 40; i++) tick();
        check("wait_forever", 64'({state, mem_error}), 64'({4'd2, 1'b0}));
`endif
        reset_n = 1'b0;
        tick();
        check("rst_abandon", 64'({state, ram_enable, mem_error}), 64'({4'd0, 1'b0, 1'b0}));
        reset_n = 1'b1; hold_low = 1'b0;
        tick();
        instr(32'h86006005, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
